// File: rtl/mdu_if.sv
// ---------------------------------------------------------------------------
// mdu_if
// Execute-stage bundle between the pipeline and the multiply/divide unit.
//
// Signals:
//   req     pipeline -> mdu   interrupt/exception taken this cycle
//   md_op   pipeline -> mdu   decoded md operation (4 bits)
//   rs      pipeline -> mdu   forwarded rs operand
//   rt      pipeline -> mdu   forwarded rt operand
//   start   mdu -> pipeline   a mult/div issues this cycle (combinational)
//   busy    mdu -> pipeline   a mult/div is in flight (registered)
//   md_out  mdu -> pipeline   HI/LO read data for mfhi/mflo
//
// Modports: master (pipeline / testbench side), slave (mdu side).
// ---------------------------------------------------------------------------
interface mdu_if;
    logic        req;
    logic [3:0]  md_op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        start;
    logic        busy;
    logic [31:0] md_out;

    modport master (
        output req, md_op, rs, rt,
        input  start, busy, md_out
    );

    modport slave (
        input  req, md_op, rs, rt,
        output start, busy, md_out
    );
endinterface

// File: rtl/mdu.sv
// ---------------------------------------------------------------------------
// mdu
// Multi-cycle multiply/divide unit with private HI/LO registers. The result
// is computed in the issue cycle and parked in hi/lo temporaries; it only
// becomes architecturally visible when the busy window runs out, so the
// pipeline sees the same timing a real iterative unit would have.
//
// Parameters:
//   MULT_CYCLES  busy duration of mult/multu (1..15)
//   DIV_CYCLES   busy duration of div/divu   (1..15)
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    mdu_if.slave (req, md_op, rs, rt, start, busy, md_out)
//
// Build option:
//   MDU_DIVZERO_KEEP_EN  when defined, a divide by zero leaves HI/LO unchanged;
//                        otherwise it commits LO=0xFFFFFFFF, HI=rs.
// ---------------------------------------------------------------------------
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic  clk,
    input logic  reset,
    mdu_if.slave bus
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    state_t      r_state;
    state_t      w_nextState;
    logic [3:0]  r_cnt;
    logic [31:0] r_hiTmp;
    logic [31:0] r_loTmp;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_isMulDiv;
    logic        w_isMult;
    logic        w_start;
    logic        w_commit;
    logic        w_signedMul;
    logic        w_signedDiv;
    logic        w_rtZero;
    logic [63:0] w_prod;
    logic [31:0] w_rsMag;
    logic [31:0] w_rtMag;
    logic [31:0] w_dividend;
    logic [31:0] w_divisor;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_quoFinal;
    logic [31:0] w_remFinal;
    logic [31:0] w_hiRes;
    logic [31:0] w_loRes;

    assign w_isMulDiv = (bus.md_op >= 4'd1) && (bus.md_op <= 4'd4);
    assign w_isMult   = (bus.md_op == 4'd1) || (bus.md_op == 4'd2);
    assign w_start    = w_isMulDiv && !bus.req && (r_state == IDLE);
    assign w_commit   = (r_state == BUSY) && (r_cnt == 4'd1);

    assign bus.start  = w_start;
    assign bus.busy   = (r_state == BUSY);

    // Sign-extending both operands to 64 bits makes a single unsigned
    // multiplier produce the correct low 64 bits for signed and unsigned.
    assign w_signedMul = (bus.md_op == 4'd1);
    assign w_prod = {{32{w_signedMul & bus.rs[31]}}, bus.rs} *
                    {{32{w_signedMul & bus.rt[31]}}, bus.rt};

    // Signed divide runs on magnitudes and fixes signs afterwards, which
    // also gives 0x80000000 / -1 = 0x80000000 without overflow trouble.
    // A zero divisor is swapped for 1 so the divider never sees it.
    assign w_signedDiv = (bus.md_op == 4'd3);
    assign w_rtZero    = (bus.rt == 32'd0);
    assign w_rsMag     = bus.rs[31] ? (32'd0 - bus.rs) : bus.rs;
    assign w_rtMag     = bus.rt[31] ? (32'd0 - bus.rt) : bus.rt;
    assign w_dividend  = w_signedDiv ? w_rsMag : bus.rs;
    assign w_divisor   = w_rtZero ? 32'd1 : (w_signedDiv ? w_rtMag : bus.rt);
    assign w_quo       = w_dividend / w_divisor;
    assign w_rem       = w_dividend % w_divisor;
    assign w_quoFinal  = (w_signedDiv && (bus.rs[31] ^ bus.rt[31])) ? (32'd0 - w_quo) : w_quo;
    assign w_remFinal  = (w_signedDiv && bus.rs[31]) ? (32'd0 - w_rem) : w_rem;

    // Result selection for the op being issued this cycle.
    always_comb begin
        w_hiRes = 32'd0;
        w_loRes = 32'd0;
        if (w_isMult) begin
            w_hiRes = w_prod[63:32];
            w_loRes = w_prod[31:0];
        end else if (w_rtZero) begin
`ifdef MDU_DIVZERO_KEEP_EN
            w_hiRes = r_hi;
            w_loRes = r_lo;
`else
            w_hiRes = bus.rs;
            w_loRes = 32'hFFFF_FFFF;
`endif
        end else begin
            w_hiRes = w_remFinal;
            w_loRes = w_quoFinal;
        end
    end

    // Next-state logic: IDLE leaves on an issue, BUSY leaves on the
    // commit edge.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_start)  w_nextState = BUSY;
            BUSY:    if (w_commit) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_nextState;
    end

    // Datapath: capture on issue, count down while busy, commit on the last
    // busy edge. mthi/mtlo only act in IDLE without req, so nothing can
    // disturb an op in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= 4'd0;
            r_hiTmp <= 32'd0;
            r_loTmp <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            if (w_start) begin
                r_hiTmp <= w_hiRes;
                r_loTmp <= w_loRes;
                r_cnt   <= w_isMult ? MULT_LOAD : DIV_LOAD;
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit) begin
                r_hi <= r_hiTmp;
                r_lo <= r_loTmp;
            end else if ((r_state == IDLE) && !bus.req) begin
                if (bus.md_op == 4'd7) r_hi <= bus.rs;
                if (bus.md_op == 4'd8) r_lo <= bus.rs;
            end
        end
    end

    assign bus.md_out = (bus.md_op == 4'd5) ? r_hi :
                        (bus.md_op == 4'd6) ? r_lo : 32'd0;

endmodule

// File: tb/tb_mdu.sv
// ---------------------------------------------------------------------------
// tb_mdu
// Self-checking bench for mdu. Stimulus issues ops and pushes expected
// mfhi/mflo read values into a queue; a negedge monitor pops and compares
// whenever md_op is a read. Expected HI/LO come from a reference model
// built on plain 64-bit arithmetic.
// ---------------------------------------------------------------------------
module tb_mdu;

    localparam int MC = 5;
    localparam int DC = 10;

    typedef struct {
        string       name;
        logic [31:0] value;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    mdu_if bus();

    mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t        expQ[$];
    int          checks = 0;
    int          passed = 0;
    logic [31:0] mHi = 32'd0;
    logic [31:0] mLo = 32'd0;

    // Single comparison point; every check funnels through here.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    endtask

    // Reference results straight from the arithmetic definitions.
    function automatic logic [63:0] refResult(input logic [3:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        longint          sa, sb, sq, sr, sp;
        longint unsigned ua, ub, uq, ur, up;
        logic [63:0]     res;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        res = 64'd0;
        case (op)
            4'd1: begin sp = sa * sb; res = sp; end
            4'd2: begin up = ua * ub; res = up; end
            default: begin
                if (b == 32'd0) begin
`ifdef MDU_DIVZERO_KEEP_EN
                    res = {mHi, mLo};
`else
                    res = {a, 32'hFFFF_FFFF};
`endif
                end else if (op == 4'd3) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    res = {sr[31:0], sq[31:0]};
                end else begin
                    uq = ua / ub;
                    ur = ua % ub;
                    res = {ur[31:0], uq[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    // Checks busy high for the remaining window, then commits the model.
    task automatic waitBusy(input int n, input logic [63:0] res);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput("busy window", {31'd0, bus.busy}, 32'd1);
            checkOutput("start during busy", {31'd0, bus.start}, 32'd0);
            @(posedge clk); #1;
            bus.md_op = 4'd0;
        end
        mHi = res[63:32];
        mLo = res[31:0];
    endtask

    // Issues one op from IDLE; entered and left at posedge+1.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic r);
        logic        expStart;
        logic [63:0] res;
        bus.md_op = op;
        bus.rs    = a;
        bus.rt    = b;
        bus.req   = r;
        expStart  = (op >= 4'd1) && (op <= 4'd4) && !r;
        res       = refResult(op, a, b);
        @(negedge clk);
        checkOutput("start at issue", {31'd0, bus.start}, {31'd0, expStart});
        checkOutput("busy at issue", {31'd0, bus.busy}, 32'd0);
        @(posedge clk); #1;
        bus.md_op = 4'd0;
        bus.req   = 1'b0;
        bus.rs    = $urandom;
        bus.rt    = $urandom;
        if (expStart) begin
            waitBusy((op <= 4'd2) ? MC : DC, res);
        end else if (!r) begin
            if (op == 4'd7) mHi = a;
            if (op == 4'd8) mLo = a;
        end
    endtask

    task automatic readBack(input string tag);
        bus.md_op = 4'd5;
        expQ.push_back('{{"mfhi ", tag}, mHi});
        @(posedge clk); #1;
        bus.md_op = 4'd6;
        expQ.push_back('{{"mflo ", tag}, mLo});
        @(posedge clk); #1;
        bus.md_op = 4'd0;
    endtask

    function automatic logic [31:0] pickOperand();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'd0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = 32'h7FFF_FFFF;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Monitor: a read pops one expectation; any other op must see md_out=0.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (bus.md_op == 4'd5 || bus.md_op == 4'd6) begin
                if (expQ.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL unexpected read: got %h expected no read", bus.md_out);
                end else begin
                    e = expQ.pop_front();
                    checkOutput(e.name, bus.md_out, e.value);
                end
            end else begin
                checkOutput("md_out non-read", bus.md_out, 32'd0);
            end
        end
    end

    initial begin
        logic [3:0]  ops [6];
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8};

        reset     = 1'b1;
        bus.req   = 1'b0;
        bus.md_op = 4'd0;
        bus.rs    = 32'd0;
        bus.rt    = 32'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("reset busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("reset start", {31'd0, bus.start}, 32'd0);
        @(posedge clk); #1;
        readBack("after reset");

        applyStimulus(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        readBack("mult");
        applyStimulus(4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0);
        readBack("multu");
        applyStimulus(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        readBack("div neg");
        applyStimulus(4'd4, 32'd7, 32'd2, 1'b0);
        readBack("divu");
        applyStimulus(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        readBack("div overflow");
        applyStimulus(4'd3, 32'd5, 32'd0, 1'b0);
        readBack("div by zero");
        applyStimulus(4'd4, 32'd9, 32'd0, 1'b0);
        readBack("divu by zero");
        applyStimulus(4'd1, 32'd6, 32'd7, 1'b1);
        readBack("mult with req");
        applyStimulus(4'd8, 32'h1234, 32'd0, 1'b1);
        readBack("mtlo with req");
        applyStimulus(4'd8, 32'h1234, 32'd0, 1'b0);
        readBack("mtlo");
        applyStimulus(4'd7, 32'h5678, 32'd0, 1'b0);
        readBack("mthi");
        // Back-to-back issue with no gap cycle between the two ops.
        applyStimulus(4'd2, 32'd100, 32'd200, 1'b0);
        applyStimulus(4'd4, 32'd100, 32'd7, 1'b0);
        readBack("back to back");

        // Reset lands in the third busy cycle: the op must vanish.
        bus.md_op = 4'd1; bus.rs = 32'd3; bus.rt = 32'd4;
        @(negedge clk);
        checkOutput("start mult 3x4", {31'd0, bus.start}, 32'd1);
        @(posedge clk); #1;
        bus.md_op = 4'd0;
        repeat (2) begin
            @(negedge clk);
            checkOutput("busy before reset", {31'd0, bus.busy}, 32'd1);
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        mHi = 32'd0;
        mLo = 32'd0;
        repeat (MC + 2) begin
            @(negedge clk);
            checkOutput("busy after reset", {31'd0, bus.busy}, 32'd0);
            @(posedge clk); #1;
        end
        readBack("reset mid-op");

        // mthi and div presented while busy must be ignored.
        bus.md_op = 4'd1; bus.rs = 32'd3; bus.rt = 32'd4;
        @(negedge clk);
        checkOutput("start mult 3x4 again", {31'd0, bus.start}, 32'd1);
        @(posedge clk); #1;
        bus.md_op = 4'd7; bus.rs = 32'hAAAA;
        @(negedge clk);
        checkOutput("mthi while busy start", {31'd0, bus.start}, 32'd0);
        @(posedge clk); #1;
        bus.md_op = 4'd3; bus.rs = 32'd100; bus.rt = 32'd7;
        @(negedge clk);
        checkOutput("div while busy start", {31'd0, bus.start}, 32'd0);
        @(posedge clk); #1;
        bus.md_op = 4'd0;
        waitBusy(MC - 2, {32'd0, 32'd12});
        readBack("ignored during busy");

        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 5)];
            a  = pickOperand();
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 : pickOperand();
            applyStimulus(op, a, b, ($urandom_range(0, 7) == 0));
            readBack($sformatf("random %0d op %0d", i, op));
        end

        repeat (2) @(posedge clk);
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
